// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the front-panel mode controller: mode encodings,
// the FSM state type and default timing parameters.
package mode_ctrl_pkg;

  localparam logic [1:0] MODE_TIME  = 2'b00;
  localparam logic [1:0] MODE_ALARM = 2'b01;
  localparam logic [1:0] MODE_STOPW = 2'b10;

  localparam int DEFAULT_DEBOUNCE_CYC = 16;
  localparam int DEFAULT_TIMEOUT_SEC  = 30;

  typedef enum logic [1:0] {
    ST_TIME  = MODE_TIME,
    ST_ALARM = MODE_ALARM,
    ST_STOPW = MODE_STOPW
  } mode_state_e;

  // The unused encoding 2'b11 falls back to TIME so the FSM always recovers.
  function automatic mode_state_e next_mode(input mode_state_e cur);
    case (cur)
      ST_TIME:  return ST_ALARM;
      ST_ALARM: return ST_STOPW;
      default:  return ST_TIME;
    endcase
  endfunction

endpackage

// File: rtl/mode_ctrl_key.sv
// key_debounce: 2-flop synchronizer, level debounce counter and a registered
// one-cycle press pulse on an accepted 0->1 transition.
module key_debounce
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synced level agrees with the accepted one,
  // so only an uninterrupted run of DEBOUNCE_CYC differing samples flips it.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mode_ctrl.sv
// Front-panel mode controller: TIME -> ALARM -> STOPWATCH sequencing plus
// stopwatch run/clear control. Define MODE_CTRL_TIMEOUT_EN for ALARM inactivity timeout.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int TIMEOUT_SEC  = DEFAULT_TIMEOUT_SEC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK_1HZ,
  input  logic       MODE_KEY,
  input  logic       START_KEY,
  input  logic       CLEAR_KEY,
  output logic       ALARMSET_RUN,
  output logic       STOPWATCH_RUN,
  output logic [1:0] MODE,
  output logic       SW_RUNNING,
  output logic       SW_CLEAR
);

  logic mode_press, start_press, clear_press;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_key (
    .clk(CLK), .rst(RST), .key_raw(MODE_KEY), .press(mode_press)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_key (
    .clk(CLK), .rst(RST), .key_raw(START_KEY), .press(start_press)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear_key (
    .clk(CLK), .rst(RST), .key_raw(CLEAR_KEY), .press(clear_press)
  );

  mode_state_e state_q, state_d;
  logic        running_q, running_d;
  logic        clear_q, clear_d;
  logic        alarm_q, alarm_d;
  logic        stopw_q, stopw_d;

`ifdef MODE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          any_press;
  assign any_press = mode_press | start_press | clear_press;
`else
  logic unused_tick;
  assign unused_tick = TICK_1HZ & (TIMEOUT_SEC > 0);
`endif

  // Key priority: MODE over START over CLEAR within a single cycle.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    clear_d   = 1'b0;
    if (mode_press) begin
      state_d = next_mode(state_q);
    end else if (start_press) begin
      if (state_q == ST_STOPW) running_d = ~running_q;
    end else if (clear_press) begin
      if (state_q == ST_STOPW && !running_q) clear_d = 1'b1;
    end
`ifdef MODE_CTRL_TIMEOUT_EN
    tcnt_d = '0;
    if (state_q == ST_ALARM && !any_press) begin
      if (TICK_1HZ) begin
        if (tcnt_q == TW'(TIMEOUT_SEC - 1)) state_d = ST_TIME;
        else                               tcnt_d  = tcnt_q + 1'b1;
      end else begin
        tcnt_d = tcnt_q;
      end
    end
`endif
    alarm_d = (state_d == ST_ALARM);
    stopw_d = (state_d == ST_STOPW);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_TIME;
      running_q <= 1'b0;
      clear_q   <= 1'b0;
      alarm_q   <= 1'b0;
      stopw_q   <= 1'b0;
`ifdef MODE_CTRL_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      clear_q   <= clear_d;
      alarm_q   <= alarm_d;
      stopw_q   <= stopw_d;
`ifdef MODE_CTRL_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign MODE          = state_q;
  assign ALARMSET_RUN  = alarm_q;
  assign STOPWATCH_RUN = stopw_q;
  assign SW_RUNNING    = running_q;
  assign SW_CLEAR      = clear_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl: table vectors, directed corner sequences
// and randomized key activity compared every cycle against a behavioural model.
module tb_mode_ctrl;

  localparam int DEB  = 4;
  localparam int TOUT = 3;

  logic       clk = 1'b0;
  logic       rst, tick, mode_key, start_key, clear_key;
  logic       alarmset_run, stopwatch_run, sw_running, sw_clear;
  logic [1:0] mode;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mode_ctrl #(.DEBOUNCE_CYC(DEB), .TIMEOUT_SEC(TOUT)) dut (
    .CLK(clk), .RST(rst), .TICK_1HZ(tick),
    .MODE_KEY(mode_key), .START_KEY(start_key), .CLEAR_KEY(clear_key),
    .ALARMSET_RUN(alarmset_run), .STOPWATCH_RUN(stopwatch_run),
    .MODE(mode), .SW_RUNNING(sw_running), .SW_CLEAR(sw_clear)
  );

  // Behavioural reference: a key level is accepted once DEB consecutive
  // synchronizer outputs (raw samples two edges old) disagree with it.
  int       m_mode;
  bit       m_running, m_clear;
  bit [2:0] m_stable, m_pending;
  int       m_tcnt;
  int       m_valid;
  bit [2:0] samp [DEB+2];

  task automatic modelStep(input bit r, input bit t, input bit [2:0] k);
    bit       was_alarm, any, s, all_diff;
    bit [2:0] press;
    if (r) begin
      m_mode = 0; m_running = 0; m_clear = 0; m_stable = '0; m_pending = '0;
      m_tcnt = 0; m_valid = 0;
      return;
    end
    press     = m_pending;
    any       = |press;
    was_alarm = (m_mode == 1);
    m_clear   = 0;
    if (press[0]) m_mode = (m_mode + 1) % 3;
    else if (press[1]) begin
      if (m_mode == 2) m_running = !m_running;
    end else if (press[2]) begin
      if (m_mode == 2 && !m_running) m_clear = 1;
    end
`ifdef MODE_CTRL_TIMEOUT_EN
    if (!was_alarm || any) m_tcnt = 0;
    else if (t) begin
      m_tcnt++;
      if (m_tcnt == TOUT) begin m_mode = 0; m_tcnt = 0; end
    end
`else
    if (t && was_alarm && any) m_tcnt = 0;
`endif
    for (int i = DEB + 1; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = k;
    m_valid++;
    for (int key = 0; key < 3; key++) begin
      all_diff = 1;
      for (int j = 0; j < DEB; j++) begin
        s = (2 + j < m_valid) ? samp[2+j][key] : 1'b0;
        if (s == m_stable[key]) all_diff = 0;
      end
      if (all_diff) begin
        m_stable[key]  = !m_stable[key];
        m_pending[key] = m_stable[key];
      end else begin
        m_pending[key] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dutVec();
    return {3'b000, mode, alarmset_run, stopwatch_run, sw_running};
  endfunction

  function automatic logic [7:0] expVec(input logic [1:0] md, input logic run);
    return {3'b000, md, md == 2'b01, md == 2'b10, run};
  endfunction

  task automatic stepCycle();
    logic [5:0] exp_all;
    @(posedge clk);
    modelStep(rst, tick, {clear_key, start_key, mode_key});
    #1;
    exp_all = {m_mode[1:0], m_mode == 1, m_mode == 2, m_running, m_clear};
    checkOutput("model", {2'b00, mode, alarmset_run, stopwatch_run, sw_running, sw_clear},
                {2'b00, exp_all});
  endtask

  task automatic applyStimulus(input logic [2:0] keys, input int hold, input int settle);
    {clear_key, start_key, mode_key} = keys;
    repeat (hold) stepCycle();
    {clear_key, start_key, mode_key} = 3'b000;
    repeat (settle) stepCycle();
  endtask

  typedef struct {
    logic [2:0] keys;
    int         hold;
    logic [1:0] exp_mode;
    logic       exp_run;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // keys = {clear, start, mode}
    vecs[0]  = '{3'b001,   6, 2'b01, 1'b0};
    vecs[1]  = '{3'b001,   3, 2'b01, 1'b0};
    vecs[2]  = '{3'b001,   6, 2'b10, 1'b0};
    vecs[3]  = '{3'b010,   6, 2'b10, 1'b1};
    vecs[4]  = '{3'b100,   6, 2'b10, 1'b1};
    vecs[5]  = '{3'b010,   6, 2'b10, 1'b0};
    vecs[6]  = '{3'b001, 200, 2'b00, 1'b0};
    vecs[7]  = '{3'b001,   4, 2'b01, 1'b0};
    vecs[8]  = '{3'b010,   6, 2'b01, 1'b0};
    vecs[9]  = '{3'b001,   6, 2'b10, 1'b0};
    vecs[10] = '{3'b010,   6, 2'b10, 1'b1};
    vecs[11] = '{3'b001,   6, 2'b00, 1'b1};
    vecs[12] = '{3'b010,   6, 2'b00, 1'b1};
    vecs[13] = '{3'b001,   6, 2'b01, 1'b1};
    vecs[14] = '{3'b001,   6, 2'b10, 1'b1};
    vecs[15] = '{3'b011,   6, 2'b00, 1'b1};
    vecs[16] = '{3'b001,   6, 2'b01, 1'b1};
    vecs[17] = '{3'b001,   6, 2'b10, 1'b1};
    vecs[18] = '{3'b110,   6, 2'b10, 1'b0};
    vecs[19] = '{3'b101,   6, 2'b00, 1'b0};

    rst = 1; tick = 0; mode_key = 0; start_key = 0; clear_key = 0;
    repeat (2) stepCycle();
    checkOutput("reset", {2'b00, mode, alarmset_run, stopwatch_run, sw_running, sw_clear}, 8'h00);
    rst = 0;
    repeat (4) stepCycle();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].keys, vecs[i].hold, 12);
      checkOutput($sformatf("table[%0d]", i), dutVec(), expVec(vecs[i].exp_mode, vecs[i].exp_run));
    end

    // Exact press latency: change lands on the 7th edge after the raw edge.
    mode_key = 1;
    repeat (6) stepCycle();
    checkOutput("latency pre", dutVec(), expVec(2'b00, 1'b0));
    stepCycle();
    checkOutput("latency 7", dutVec(), expVec(2'b01, 1'b0));
    mode_key = 0;
    repeat (12) stepCycle();

    // Stopwatch clear pulse while stopped.
    applyStimulus(3'b001, 6, 12);
    clear_key = 1;
    repeat (6) stepCycle();
    checkOutput("clear pre", {7'd0, sw_clear}, 8'd0);
    stepCycle();
    checkOutput("clear pulse", {7'd0, sw_clear}, 8'd1);
    stepCycle();
    checkOutput("clear one cycle", {7'd0, sw_clear}, 8'd0);
    clear_key = 0;
    repeat (12) stepCycle();

    // Reset mid-operation with MODE held through it.
    applyStimulus(3'b010, 6, 12);
    checkOutput("pre reset", dutVec(), expVec(2'b10, 1'b1));
    mode_key = 1; rst = 1;
    stepCycle();
    checkOutput("reset mid-op", {2'b00, mode, alarmset_run, stopwatch_run, sw_running, sw_clear}, 8'h00);
    rst = 0;
    repeat (6) stepCycle();
    checkOutput("held key pre", dutVec(), expVec(2'b00, 1'b0));
    stepCycle();
    checkOutput("held key 7", dutVec(), expVec(2'b01, 1'b0));
    mode_key = 0;
    repeat (12) stepCycle();

`ifdef MODE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick = 1; stepCycle(); tick = 0;
      checkOutput($sformatf("timeout tick %0d", i + 1), dutVec(),
                  expVec((i < 2) ? 2'b01 : 2'b00, 1'b0));
      repeat (3) stepCycle();
    end
    applyStimulus(3'b001, 6, 12);
    for (int i = 0; i < 2; i++) begin
      tick = 1; stepCycle(); tick = 0;
      repeat (3) stepCycle();
    end
    applyStimulus(3'b010, 6, 12);
    for (int i = 0; i < 3; i++) begin
      tick = 1; stepCycle(); tick = 0;
      checkOutput($sformatf("rearm tick %0d", i + 1), dutVec(),
                  expVec((i < 2) ? 2'b01 : 2'b00, 1'b0));
      repeat (3) stepCycle();
    end
`else
    for (int i = 0; i < 10; i++) begin
      tick = 1; stepCycle(); tick = 0;
      repeat (3) stepCycle();
    end
    checkOutput("no timeout", dutVec(), expVec(2'b01, 1'b0));
`endif

    // Randomized key activity against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5, 0) == 0) mode_key  = 1'($urandom_range(1, 0));
      if ($urandom_range(5, 0) == 0) start_key = 1'($urandom_range(1, 0));
      if ($urandom_range(5, 0) == 0) clear_key = 1'($urandom_range(1, 0));
      tick = ($urandom_range(19, 0) == 0);
      rst  = ($urandom_range(499, 0) == 0);
      stepCycle();
    end
    rst = 0; tick = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
